// File: rtl/match_event_capture_if.sv
// Read-side handshake of the match capture FIFO: head entry plus valid/ready.
// The capture block is the master; the downstream reader is the slave.
interface match_event_capture_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TS_WIDTH = 32
);
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [TS_WIDTH-1:0] out_ts;

    modport master (output out_valid, output out_data, output out_ts, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ts, output out_ready);
endinterface

// File: rtl/match_event_capture.sv
// Captures {bus word, timestamp} on each qualified match pulse into a FWFT FIFO,
// with a sticky overflow flag and a saturating drop counter.
module match_event_capture #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TS_WIDTH = 32,
    parameter int unsigned ADDR     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  match,
    input  logic [WIDTH-1:0]      data_in,
    match_event_capture_if.master out_bus,
    output logic [ADDR:0]         count,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int unsigned Depth  = 2 ** ADDR;
    localparam int unsigned EntryW = WIDTH + TS_WIDTH;

    logic [EntryW-1:0]   mem_q [Depth];
    logic [ADDR-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]       count_q, count_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_q, drop_d;

    logic                push_req, full, empty, do_pop, do_push, drop;
    logic [EntryW-1:0]   head;

    always_comb begin
        push_req = match & enable;
        // count never exceeds Depth, so its top bit alone means full
        full     = count_q[ADDR];
        empty    = (count_q == '0);
        do_pop   = ~empty & out_bus.out_ready;
        do_push  = push_req & (~full | do_pop);
        drop     = push_req & full & ~do_pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ts_d       = ts_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ts_d       = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (enable) ts_d = ts_q + TS_WIDTH'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + ADDR'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (ADDR + 1)'(1);
                2'b01:   count_d = count_q - (ADDR + 1)'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: reads are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= {data_in, ts_q};
    end

    always_comb begin
        head              = mem_q[rd_ptr_q];
        out_bus.out_valid = ~empty;
        out_bus.out_data  = empty ? '0 : head[EntryW-1:TS_WIDTH];
        out_bus.out_ts    = empty ? '0 : head[TS_WIDTH-1:0];
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: doc/match_event_capture.md
# match_event_capture

Sniffer-side consumer of the one-cycle match pulses produced by the bus comparators. Each qualified match pushes the sampled bus word and a free-running timestamp into a small FIFO. A downstream reader (AXI bridge or trace formatter) drains the FIFO through a valid/ready handshake. Overflow is reported by a sticky flag and a saturating drop counter.

## Interface
Parameters:
- WIDTH, 32, width of the captured bus word
- TS_WIDTH, 32, timestamp counter width
- ADDR, 3, FIFO address bits; depth = 2^ADDR (default 8)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- enable  input  1  capture enable; gates timestamp counting and pushes
- clear  input  1  synchronous flush: empties FIFO, zeroes timestamp, drop counter, overflow
- match  input  1  match pulse from comparator, level-sampled each cycle
- data_in  input  WIDTH  bus word, sampled in the same cycle as match
- out_valid  output  1  FIFO head entry available
- out_ready  input  1  reader accepts head entry
- out_data  output  WIDTH  head entry bus word
- out_ts  output  TS_WIDTH  head entry timestamp
- count  output  ADDR+1  current FIFO occupancy, 0..2^ADDR
- overflow  output  1  sticky: at least one match was dropped
- drop_count  output  8  number of dropped matches, saturates at 255

## Operation
- Reset values: out_valid 0, count 0, overflow 0, drop_count 0, timestamp 0. out_data and out_ts are 0 while empty.
- Timestamp: increments by 1 every cycle with enable=1. It holds when enable=0 and wraps modulo 2^TS_WIDTH with no flag.
- Push request: match && enable in a cycle. The entry written is {data_in, timestamp value in that same cycle}, i.e. the pre-increment value.
- Pop: out_valid && out_ready at a rising edge. Pops are allowed regardless of enable.
- FIFO: first-word-fall-through. out_valid = (count != 0). out_data/out_ts always show the oldest entry.
- Full (count = 2^ADDR) with push request and no pop:
  - the entry is dropped; FIFO contents are unchanged;
  - overflow is set;
  - drop_count increments, saturating at 255.
- Full with push and pop in the same cycle: both occur; count stays 2^ADDR; no drop.
- Empty with push and pop: the pop is impossible (out_valid=0), so only the push occurs.
- Push and pop when neither full nor empty: count unchanged; order preserved.
- Pointers: ADDR-bit read/write pointers wrap modulo depth. count is tracked explicitly.
- clear takes priority over push/pop in the same cycle:
  - next cycle count=0, out_valid=0, timestamp=0, overflow=0, drop_count=0;
  - a coincident match is discarded and not counted as a drop.
- Asynchronous reset mid-transfer: all state is cleared immediately. There is no partial entry and no out_valid glitch after reset deasserts.

## Timing
- Push latency: match sampled at edge k → count and out_valid updated after edge k (visible in cycle k+1). If the FIFO was empty, out_data/out_ts show the new entry in cycle k+1.
- Pop: the head advances after the edge where out_valid && out_ready. The next entry is visible the following cycle. The reader may hold out_ready high for one entry per cycle.
- out_valid never deasserts without a pop, clear, or reset.
- overflow and drop_count update one edge after the dropped match.
- Back-to-back matches every cycle are accepted at full rate until full.

## Test plan
- Reset, enable=1, out_ready=0; match at ts=3 and ts=7 with data 0xAAAA0001 and 0xAAAA0002 → count=2; head = {0xAAAA0001, 3}; after one pop, head = {0xAAAA0002, 7}.
- 10 consecutive matches with depth 8 and out_ready=0 → count=8, overflow=1, drop_count=2. Draining yields the first 8 words in order.
- FIFO full, match and pop in the same cycle → count stays 8, drop_count unchanged, new entry becomes the last element.
- enable=0 for 5 cycles with match pulses → no pushes, timestamp frozen. Pops of existing entries still complete.
- TS_WIDTH=4: run 20 enabled cycles with a match at cycle 17 → captured ts=1 (wrap). Then assert clear with a coincident match → count=0, overflow=0, drop_count=0, no entry stored.
- Assert reset while out_valid=1 and out_ready=1 mid-drain → outputs zero immediately. After release, no stale entry appears.
